// File: rtl/dpram_be.sv
// dpram_be: single-clock true dual-port RAM with per-byte write enables,
// selectable read-during-write behaviour and a built-in clear engine.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clr                   one-cycle request to start/restart a clear
//   busy                  high while the clear engine owns the array
//   a_en/a_be/a_addr/a_din/a_dout   port A: enable, byte write enables
//                         (all zero = read), address, write data, registered
//                         read data
//   b_en/b_be/b_addr/b_din/b_dout   port B: same as port A
//
// Collision rules: a port reading the address the other port writes sees the
// old word; when both ports write one address, A owns its enabled lanes, B
// gets the lanes only it enables.

module dpram_be #(
  parameter int unsigned     DATA           = 32,
  parameter int unsigned     ADDR           = 10,
  parameter bit              WRITE_FIRST    = 1'b1,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA-1:0] INIT_VAL       = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                busy,
  input  logic                a_en,
  input  logic [DATA/8-1:0]   a_be,
  input  logic [ADDR-1:0]     a_addr,
  input  logic [DATA-1:0]     a_din,
  output logic [DATA-1:0]     a_dout,
  input  logic                b_en,
  input  logic [DATA/8-1:0]   b_be,
  input  logic [ADDR-1:0]     b_addr,
  input  logic [DATA-1:0]     b_din,
  output logic [DATA-1:0]     b_dout
);

  localparam int unsigned BYTES = DATA / 8;
  localparam int unsigned DEPTH = 2 ** ADDR;

  // Clear engine states. PEND behaves exactly like CLEAR (it writes mem[cnt]);
  // it only marks that the clear was started by reset rather than by clr.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_RESET = CLEAR_ON_RESET ? ST_PEND : ST_IDLE;

  logic [DATA-1:0] mem [DEPTH];

  logic [1:0]      state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic            clr_we;
  logic [DATA-1:0] a_dout_q, a_dout_d;
  logic [DATA-1:0] b_dout_q, b_dout_d;

  logic            a_acc, b_acc, a_wr, b_wr, b_hit;
  logic [DATA-1:0] a_old, b_old, a_new, b_new, a_wdata;

  assign busy   = (state_q != ST_IDLE);
  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;

  // ---------------------------------------------------------------------------
  // Clear engine: one word per cycle, 2**ADDR cycles. A clr restarts at 0 and
  // that cycle performs no write, so a restart costs exactly one extra cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (clr) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else if (state_q != ST_IDLE) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      state_d = (cnt_q == {ADDR{1'b1}}) ? ST_IDLE : ST_CLEAR;
    end
  end

  // ---------------------------------------------------------------------------
  // Port datapath. Ports are fully gated while busy: no writes, douts hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_acc = a_en && !busy;
    b_acc = b_en && !busy;
    a_wr  = a_acc && (|a_be);
    b_wr  = b_acc && (|b_be);
    b_hit = b_wr && (b_addr == a_addr);
    a_old = mem[a_addr];
    b_old = mem[b_addr];
    a_new   = a_old;
    b_new   = b_old;
    a_wdata = a_old;
    for (int i = 0; i < BYTES; i++) begin
      if (a_be[i]) a_new[8*i +: 8] = a_din[8*i +: 8];
      if (b_be[i]) b_new[8*i +: 8] = b_din[8*i +: 8];
      // Word A stores: its own lanes first, B's lanes when both hit one word.
      if (a_be[i])                a_wdata[8*i +: 8] = a_din[8*i +: 8];
      else if (b_hit && b_be[i])  a_wdata[8*i +: 8] = b_din[8*i +: 8];
    end
    // Each port's dout uses only its own data, so the cross-port case always
    // reads the pre-write word.
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    if (a_acc) a_dout_d = WRITE_FIRST ? a_new : a_old;
    if (b_acc) b_dout_d = WRITE_FIRST ? b_new : b_old;
  end

  // NOTE: the array has no reset; resetting a RAM would turn it into flops.
  // The clear engine provides the defined contents instead.
  always_ff @(posedge clk) begin
    if (clr_we) mem[cnt_q] <= INIT_VAL;
    if (b_wr)   mem[b_addr] <= b_new;
    // NOTE: with non-blocking assignments the last one to the same element
    // wins, so A's write (already holding B's lanes) is placed after B's.
    if (a_wr)   mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

endmodule

// File: tb/tb_dpram_be.sv
// Self-checking bench for dpram_be. Two instances share all inputs:
//   u_dut : ADDR=4, WRITE_FIRST=1, CLEAR_ON_RESET=1, INIT_VAL=DEADBEEF
//   u_wf0 : ADDR=4, WRITE_FIRST=0, CLEAR_ON_RESET=0, INIT_VAL=0
// Expected read data is queued when a request is driven and compared after
// the clock edge that produces it.

module tb_dpram_be;

  localparam int unsigned DATA = 32;
  localparam int unsigned ADDR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic            a_en, b_en;
  logic [3:0]      a_be, b_be;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [DATA-1:0] a_din, b_din;
  logic [DATA-1:0] a_dout, b_dout, w0_a_dout, w0_b_dout;
  logic            busy, w0_busy;

  always #5 clk = ~clk;

  dpram_be #(
    .DATA(DATA), .ADDR(ADDR), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1),
    .INIT_VAL(32'hDEADBEEF)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .a_en(a_en), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .b_en(b_en), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout)
  );

  dpram_be #(
    .DATA(DATA), .ADDR(ADDR), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b0),
    .INIT_VAL(32'h0)
  ) u_wf0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(w0_busy),
    .a_en(a_en), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(w0_a_dout),
    .b_en(b_en), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(w0_b_dout)
  );

  typedef enum {SEL_A, SEL_B, SEL_A0, SEL_B0} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
  endtask

  task automatic expect_out(input string tag, input sel_e sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_A:   obs = a_dout;
        SEL_B:   obs = b_dout;
        SEL_A0:  obs = w0_a_dout;
        default: obs = w0_b_dout;
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are compared at the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic idle_ports();
    a_en = 1'b0; a_be = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_be = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic drive_a(input logic [ADDR-1:0] addr, input logic [3:0] be, input logic [31:0] din);
    a_en = 1'b1; a_addr = addr; a_be = be; a_din = din;
  endtask

  task automatic drive_b(input logic [ADDR-1:0] addr, input logic [3:0] be, input logic [31:0] din);
    b_en = 1'b1; b_addr = addr; b_be = be; b_din = din;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    idle_ports();

    // ---- reset state --------------------------------------------------------
    drive_a(4'd0, 4'h0, '0);
    @(negedge clk);
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_b_dout", b_dout, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_busy_wf0", {31'b0, w0_busy}, 32'd0);

    // ---- auto-clear after release; a read is held off while busy ------------
    rst_n = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (busy && cyc < 64);
    check("auto_clear_len", cyc, 32'd16);
    check("dout_hold_auto_clear", a_dout, 32'h0);
    idle_ports();

    for (int i = 0; i < 16; i++) begin
      drive_a(ADDR'(i), 4'h0, '0);
      drive_b(ADDR'(15 - i), 4'h0, '0);
      expect_out($sformatf("clear_rd_a%0d", i), SEL_A, 32'hDEADBEEF);
      expect_out($sformatf("clear_rd_b%0d", 15 - i), SEL_B, 32'hDEADBEEF);
      step();
    end
    idle_ports();

    // ---- byte-enable merge --------------------------------------------------
    drive_a(4'd5, 4'hF, 32'h11223344);
    expect_out("be_wr_full", SEL_A, 32'h11223344);
    step();
    drive_a(4'd5, 4'b0101, 32'hAABBCCDD);
    expect_out("be_wr_part_wf", SEL_A, 32'h11BB33DD);
    step();
    drive_a(4'd5, 4'h0, '0);
    expect_out("be_merge_rd", SEL_A, 32'h11BB33DD);
    step();

    // ---- same-port read-during-write ----------------------------------------
    drive_a(4'd3, 4'hF, 32'h0);
    step();
    drive_a(4'd3, 4'hF, 32'h12345678);
    expect_out("rdw_write_first", SEL_A, 32'h12345678);
    expect_out("rdw_read_first", SEL_A0, 32'h00000000);
    step();

    // ---- collisions ---------------------------------------------------------
    drive_a(4'd7, 4'hF, 32'h0);
    step();
    drive_a(4'd7, 4'b0011, 32'hFFFFFFFF);
    drive_b(4'd7, 4'b0110, 32'h55555555);
    expect_out("coll_a_dout", SEL_A, 32'h0000FFFF);
    expect_out("coll_b_dout", SEL_B, 32'h00555500);
    expect_out("coll_a_dout_wf0", SEL_A0, 32'h0);
    expect_out("coll_b_dout_wf0", SEL_B0, 32'h0);
    step();
    idle_ports();
    drive_b(4'd7, 4'h0, '0);
    expect_out("coll_merge_rd", SEL_B, 32'h0055FFFF);
    expect_out("coll_merge_rd_wf0", SEL_B0, 32'h0055FFFF);
    step();
    drive_a(4'd7, 4'hF, 32'h00000001);
    drive_b(4'd7, 4'h0, '0);
    expect_out("xport_b_old", SEL_B, 32'h0055FFFF);
    expect_out("xport_a_new", SEL_A, 32'h00000001);
    step();
    drive_a(4'd7, 4'h0, '0);
    drive_b(4'd5, 4'h0, '0);
    expect_out("xport_after_a", SEL_A, 32'h00000001);
    expect_out("xport_after_b", SEL_B, 32'h11BB33DD);
    step();
    idle_ports();

    // ---- clr, restart after 5 cycles, gating of writes and douts ------------
    clr = 1'b1;
    step();
    clr = 1'b0;
    cyc = busy ? 1 : 0;
    while (busy && cyc < 64) begin
      clr = (cyc == 5);
      drive_a(4'd9, 4'hF, 32'h12345678);
      drive_b(4'd10, 4'hF, 32'hCAFEF00D);
      step();
      if (busy) cyc++;
    end
    clr = 1'b0;
    idle_ports();
    check("clr_restart_len", cyc, 32'd21);
    check("busy_hold_a", a_dout, 32'h00000001);
    check("busy_hold_b", b_dout, 32'h11BB33DD);
    drive_a(4'd9, 4'h0, '0);
    drive_b(4'd10, 4'h0, '0);
    expect_out("busy_wr_dropped_a", SEL_A, 32'hDEADBEEF);
    expect_out("busy_wr_dropped_b", SEL_B, 32'hDEADBEEF);
    step();
    drive_a(4'd5, 4'h0, '0);
    expect_out("clr_overwrite", SEL_A, 32'hDEADBEEF);
    expect_out("clr_wf0_init", SEL_A0, 32'h0);
    step();
    idle_ports();

    // ---- async reset in the middle of a clear -------------------------------
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a_dout", a_dout, 32'h0);
    check("async_rst_b_dout", b_dout, 32'h0);
    check("async_rst_busy", {31'b0, busy}, 32'd1);
    check("async_rst_busy_wf0", {31'b0, w0_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (busy && cyc < 64);
    check("reclear_len", cyc, 32'd16);
    check("reclear_wf0_idle", {31'b0, w0_busy}, 32'd0);
    drive_a(4'd15, 4'h0, '0);
    drive_b(4'd8, 4'h0, '0);
    expect_out("reclear_rd_a", SEL_A, 32'hDEADBEEF);
    expect_out("reclear_rd_b", SEL_B, 32'hDEADBEEF);
    step();
    idle_ports();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
- Single-clock true dual-port RAM. Successor to the two-clock plain dual-port RAM.
- Adds per-byte write enables, a selectable read-during-write mode, and a defined same-cycle collision policy.
- Adds a built-in clear engine that fills the array with a constant after reset or on request.
- Used for CPU/video shared buffers where software needs a known-clean memory and byte-granular writes.

Parameters:
- DATA, 32, word width in bits; must be a multiple of 8; BYTES = DATA/8.
- ADDR, 10, address width; depth = 2**ADDR words.
- WRITE_FIRST, 1, 1: same-port read-during-write returns the newly written word; 0: returns the old word.
- CLEAR_ON_RESET, 1, 1: clear engine runs automatically after rst_n deasserts; 0: only on clr.
- INIT_VAL, 0, DATA-bit fill value written by the clear engine.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  one-cycle request to start or restart a clear.
- busy  out  1  high while the clear engine owns the array.
- a_en  in  1  port A access enable.
- a_be  in  BYTES  port A byte write enables; 0 means read.
- a_addr  in  ADDR  port A address.
- a_din  in  DATA  port A write data.
- a_dout  out  DATA  port A read data, registered.
- b_en  in  1  port B access enable.
- b_be  in  BYTES  port B byte write enables.
- b_addr  in  ADDR  port B address.
- b_din  in  DATA  port B write data.
- b_dout  out  DATA  port B read data, registered.

Behaviour:
- Reset (rst_n low, async):
  - a_dout = b_dout = 0.
  - busy = CLEAR_ON_RESET.
  - Clear counter = 0; clear state = CLR_PEND if CLEAR_ON_RESET, else IDLE.
  - Array contents are not reset.
- Clear FSM states:
  - IDLE -> CLEARING: on clr, or at the first clock after reset release when in CLR_PEND.
  - CLEARING: write INIT_VAL to mem[cnt] each cycle, then cnt++.
  - CLEARING -> IDLE: after writing address 2**ADDR-1; busy falls on that same edge.
  - Clear duration is exactly 2**ADDR cycles.
- clr while CLEARING: cnt restarts at 0; busy stays high.
- Reset asserted mid-clear: aborts immediately; the clear restarts from 0 after release (CLEAR_ON_RESET=1), or the engine stays IDLE (CLEAR_ON_RESET=0).
- While busy = 1:
  - Port writes are dropped.
  - a_dout and b_dout hold their previous values.
  - en is ignored.
- Normal access (busy = 0, x_en = 1):
  - Read latency is 1 cycle: x_dout on edge N+1 reflects the address presented at edge N.
  - For lanes with x_be[i] = 1, byte i of mem[x_addr] is replaced by x_din byte i. Other lanes are unchanged.
- x_en = 0: no write; x_dout holds.
- Same-port read-during-write:
  - WRITE_FIRST = 1: x_dout is the merged new word (new bytes in enabled lanes, old bytes elsewhere).
  - WRITE_FIRST = 0: x_dout is the pre-write word.
- Cross-port, same address, same cycle: the reading port always returns the pre-write (old) word, independent of WRITE_FIRST.
- Both ports write the same address in the same cycle:
  - Lanes enabled on A take A's data.
  - Lanes enabled only on B take B's data.
  - Port A wins overlapping lanes.
  - Each port's own dout follows its WRITE_FIRST rule using its own data only.
- Address wraps naturally at ADDR bits; there is no out-of-range case.

Test Plan:
- Reset and auto-clear, ADDR=4, INIT_VAL=32'hDEADBEEF, CLEAR_ON_RESET=1: release rst_n -> busy=1 for exactly 16 cycles, then 0; reads of all 16 addresses return DEADBEEF; douts are 0 during reset.
- Byte-enable merge: write A addr 5 din 11223344 be 1111, then be 0101 din AABBCCDD -> read addr 5 returns 11BB33DD one cycle after the read address.
- Read-during-write: WRITE_FIRST=1, mem[3]=0, A writes 12345678 be 1111 -> a_dout=12345678 next cycle. Same stimulus with WRITE_FIRST=0 -> a_dout=00000000.
- Collision: mem[7]=00000000; A writes FFFFFFFF be 0011, B writes 55555555 be 0110 at addr 7 in the same cycle -> mem[7]=0055FFFF. B reading addr 7 while A writes 1 in the same cycle -> b_dout=old value.
- Clear restart and gating: pulse clr, pulse clr again 5 cycles later -> busy high for 5+16 cycles total; port writes issued while busy are absent afterwards (addr reads INIT_VAL); douts hold while busy.
- Async reset mid-clear: assert rst_n low at cycle 8 of a clear, asynchronously mid-cycle -> douts go 0 immediately; after release, busy stays high for 16 full cycles (CLEAR_ON_RESET=1).
